// File: rtl/multi_fifo_drain_arbiter.sv
// Round-robin read engine for the shared linked-list multi-FIFO with a 2-entry output buffer.
// Define DRAIN_BURST_EN to allow up to BURST consecutive grants to the same queue.
module multi_fifo_drain_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NUM_FIFOS = 2,
    parameter int SEL_WIDTH = $clog2(NUM_FIFOS),
    parameter int BURST     = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NUM_FIFOS-1:0] empty,
    input  logic [WIDTH-1:0]     fifo_data,
    output logic                 pop,
    output logic [SEL_WIDTH-1:0] pop_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_WIDTH-1:0] out_sel,
    output logic [CNT_WIDTH-1:0] pop_cnt
);

    localparam logic [SEL_WIDTH:0] NUM_EXT = (SEL_WIDTH+1)'(NUM_FIFOS);

    logic [SEL_WIDTH-1:0] rr_ptr;
    logic [SEL_WIDTH-1:0] cand;
    logic [SEL_WIDTH-1:0] rr_next;
    logic                 any_ready;
    logic [1:0]           count;
    logic [WIDTH-1:0]     slot_data;
    logic [SEL_WIDTH-1:0] slot_sel;
    logic                 transfer;

    // Scan downwards so the queue closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        logic [SEL_WIDTH:0] idx;
        logic [SEL_WIDTH:0] nxt;
        cand      = rr_ptr;
        any_ready = 1'b0;
        idx       = '0;
        for (int k = NUM_FIFOS - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr} + (SEL_WIDTH+1)'(k);
            if (idx >= NUM_EXT) begin
                idx = idx - NUM_EXT;
            end
            if (!empty[idx[SEL_WIDTH-1:0]]) begin
                cand      = idx[SEL_WIDTH-1:0];
                any_ready = 1'b1;
            end
        end
        nxt = {1'b0, cand} + 1'b1;
        if (nxt >= NUM_EXT) begin
            nxt = '0;
        end
        rr_next = nxt[SEL_WIDTH-1:0];
    end

    // Pop depends only on registered buffer occupancy, never on out_ready.
    assign pop       = rst & en & (count != 2'd2) & any_ready;
    assign pop_sel   = pop ? cand : rr_ptr;
    assign out_valid = (count != 2'd0);
    assign transfer  = out_valid & out_ready;

`ifdef DRAIN_BURST_EN
    localparam int BW = $clog2(BURST) + 1;
    logic [BW-1:0] burst_cnt;
`else
    logic unused_burst;
    assign unused_burst = (BURST > 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr    <= '0;
            count     <= 2'd0;
            out_data  <= '0;
            out_sel   <= '0;
            slot_data <= '0;
            slot_sel  <= '0;
            pop_cnt   <= '0;
`ifdef DRAIN_BURST_EN
            burst_cnt <= '0;
`endif
        end else begin
            if (pop) begin
                pop_cnt <= pop_cnt + 1'b1;
`ifdef DRAIN_BURST_EN
                // Empty flags lag a cycle, so only the current flag and cand steer rotation.
                if (cand == rr_ptr && burst_cnt < BW'(BURST - 1)) begin
                    burst_cnt <= burst_cnt + 1'b1;
                end else begin
                    rr_ptr    <= rr_next;
                    burst_cnt <= '0;
                end
`else
                rr_ptr <= rr_next;
`endif
            end

            if (pop && (count == 2'd0 || (count == 2'd1 && transfer))) begin
                out_data <= fifo_data;
                out_sel  <= pop_sel;
            end else if (pop) begin
                slot_data <= fifo_data;
                slot_sel  <= pop_sel;
            end else if (transfer && count == 2'd2) begin
                out_data <= slot_data;
                out_sel  <= slot_sel;
            end

            case ({pop, transfer})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_fifo_drain_arbiter.sv
// Directed bench for multi_fifo_drain_arbiter with a small shared-FIFO model (2 queues).
// Define DRAIN_BURST_EN for both files to also run the burst ordering case.
module tb_multi_fifo_drain_arbiter;

    localparam int W = 8;
    localparam int N = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          out_ready = 1'b0;
    logic [N-1:0]  empty;
    logic [W-1:0]  fifo_data;
    logic          pop;
    logic          pop_sel;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_sel;
    logic [15:0]   pop_cnt;

    logic [W-1:0]  qmem [N][8];
    logic [3:0]    head [N] = '{4'd0, 4'd0};
    logic [3:0]    tail [N] = '{4'd0, 4'd0};

    int check_count = 0;
    int fail_count = 0;
    int cycle_num = 0;
    int pop_log[$];
    int pop_cyc[$];
    int out_log[$];
    int out_cyc[$];

    multi_fifo_drain_arbiter #(
        .WIDTH(W), .NUM_FIFOS(N), .SEL_WIDTH(1), .BURST(2), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .empty(empty), .fifo_data(fifo_data),
        .pop(pop), .pop_sel(pop_sel), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sel(out_sel), .pop_cnt(pop_cnt)
    );

    always #5 clk = ~clk;

    assign empty[0]  = (head[0] == tail[0]);
    assign empty[1]  = (head[1] == tail[1]);
    assign fifo_data = qmem[pop_sel][head[pop_sel][2:0]];

    always @(posedge clk) begin
        if (pop) head[pop_sel] <= head[pop_sel] + 4'd1;
    end

    task automatic checkOutput(input string tag, input int got, input int exp);
        check_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs are stable from posedge+2 to the next posedge, so negedge sees the upcoming edge.
    always @(negedge clk) begin
        cycle_num++;
        if (pop) begin
            pop_log.push_back(int'(pop_sel));
            pop_cyc.push_back(cycle_num);
            checkOutput("popNotEmpty", int'(empty[pop_sel]), 0);
        end
        if (out_valid && out_ready) begin
            out_log.push_back({23'd0, out_sel, out_data});
            out_cyc.push_back(cycle_num);
        end
    end

    task automatic push_q(input int q, input logic [W-1:0] d);
        qmem[q][tail[q][2:0]] = d;
        tail[q] = tail[q] + 4'd1;
    endtask

    task automatic applyStimulus(input logic en_v, input logic ready_v, input int cycles);
        en = en_v;
        out_ready = ready_v;
        repeat (cycles) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic int pop_at(input int i);
        return (i < pop_log.size()) ? pop_log[i] : 32'hDEAD;
    endfunction

    function automatic int out_at(input int i);
        return (i < out_log.size()) ? out_log[i] : 32'hDEAD;
    endfunction

    function automatic int ent(input int sel, input int data);
        return (sel << 8) | data;
    endfunction

    initial begin
        int p0;
        int o0;
        int exp_out[6];
        int exp_pop[6];

        #1;
        checkOutput("rstValid", int'(out_valid), 0);
        checkOutput("rstPop", int'(pop), 0);
        checkOutput("rstPopCnt", int'(pop_cnt), 0);
        checkOutput("rstData", int'(out_data), 0);
        checkOutput("rstSel", int'(out_sel), 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 2);
        checkOutput("idlePop", int'(pop), 0);

        $display("[TB] interleave");
        p0 = pop_log.size();
        o0 = out_log.size();
        push_q(0, 8'hA1); push_q(0, 8'hA2);
        push_q(1, 8'hB1); push_q(1, 8'hB2);
        applyStimulus(1'b1, 1'b1, 7);
        exp_out[0] = ent(0, 'hA1); exp_out[1] = ent(1, 'hB1);
        exp_out[2] = ent(0, 'hA2); exp_out[3] = ent(1, 'hB2);
        for (int i = 0; i < 4; i++) begin
            checkOutput("ilvPopSel", pop_at(p0 + i), i % 2);
            checkOutput("ilvOut", out_at(o0 + i), exp_out[i]);
        end
        checkOutput("ilvOutCount", out_log.size() - o0, 4);
        checkOutput("ilvPopCnt", int'(pop_cnt), 4);

        $display("[TB] backpressure");
        p0 = pop_log.size();
        o0 = out_log.size();
        out_ready = 1'b0;
        push_q(0, 8'hC0); push_q(0, 8'hC1); push_q(0, 8'hC2);
        push_q(1, 8'hD0); push_q(1, 8'hD1); push_q(1, 8'hD2);
        applyStimulus(1'b1, 1'b0, 6);
        checkOutput("bpPopCnt", int'(pop_cnt), 6);
        checkOutput("bpPop", int'(pop), 0);
        checkOutput("bpValid", int'(out_valid), 1);
        checkOutput("bpData", int'(out_data), 'hC0);
        checkOutput("bpSel", int'(out_sel), 0);
        applyStimulus(1'b1, 1'b0, 3);
        checkOutput("bpDataHold", int'(out_data), 'hC0);
        checkOutput("bpPopCntHold", int'(pop_cnt), 6);
        applyStimulus(1'b1, 1'b1, 9);
        exp_out[0] = ent(0, 'hC0); exp_out[1] = ent(1, 'hD0);
        exp_out[2] = ent(0, 'hC1); exp_out[3] = ent(1, 'hD1);
        exp_out[4] = ent(0, 'hC2); exp_out[5] = ent(1, 'hD2);
        exp_pop = '{0, 1, 0, 1, 0, 1};
        for (int i = 0; i < 6; i++) begin
            checkOutput("bpOut", out_at(o0 + i), exp_out[i]);
            checkOutput("bpPopSel", pop_at(p0 + i), exp_pop[i]);
        end
        checkOutput("bpOutCount", out_log.size() - o0, 6);
        checkOutput("bpPopCntEnd", int'(pop_cnt), 10);

        $display("[TB] single queue");
        p0 = pop_log.size();
        o0 = out_log.size();
        for (int i = 0; i < 5; i++) push_q(1, W'(8'hE0 + i));
        applyStimulus(1'b1, 1'b1, 8);
        for (int i = 0; i < 5; i++) begin
            checkOutput("sqPopSel", pop_at(p0 + i), 1);
            checkOutput("sqOut", out_at(o0 + i), ent(1, 'hE0 + i));
        end
        checkOutput("sqPopCount", pop_log.size() - p0, 5);
        checkOutput("sqPopSpan", pop_cyc[p0 + 4] - pop_cyc[p0], 4);
        checkOutput("sqOutSpan", out_cyc[o0 + 4] - out_cyc[o0], 4);
        checkOutput("sqPopCnt", int'(pop_cnt), 15);

        $display("[TB] enable gating");
        o0 = out_log.size();
        push_q(0, 8'hF0); push_q(0, 8'hF1); push_q(0, 8'hF2);
        applyStimulus(1'b1, 1'b0, 4);
        checkOutput("enFullPop", int'(pop), 0);
        checkOutput("enPopCnt", int'(pop_cnt), 17);
        applyStimulus(1'b0, 1'b1, 4);
        checkOutput("enDrain0", out_at(o0), ent(0, 'hF0));
        checkOutput("enDrain1", out_at(o0 + 1), ent(0, 'hF1));
        checkOutput("enDrainValid", int'(out_valid), 0);
        checkOutput("enOffPop", int'(pop), 0);
        checkOutput("enOffPopCnt", int'(pop_cnt), 17);
        en = 1'b1;
        #1;
        checkOutput("enOnPop", int'(pop), 1);
        checkOutput("enOnPopSel", int'(pop_sel), 0);
        applyStimulus(1'b1, 1'b1, 3);
        checkOutput("enResume", out_at(o0 + 2), ent(0, 'hF2));
        checkOutput("enResumePopCnt", int'(pop_cnt), 18);

        $display("[TB] reset mid-stream");
        push_q(0, 8'h5A); push_q(1, 8'h6B);
        applyStimulus(1'b1, 1'b0, 4);
        checkOutput("mrPreValid", int'(out_valid), 1);
        checkOutput("mrPrePopCnt", int'(pop_cnt), 20);
        checkOutput("mrPreData", int'(out_data), 'h6B);
        rst = 1'b0;
        #1;
        checkOutput("mrValid", int'(out_valid), 0);
        checkOutput("mrPop", int'(pop), 0);
        checkOutput("mrPopCnt", int'(pop_cnt), 0);
        checkOutput("mrData", int'(out_data), 0);
        applyStimulus(1'b1, 1'b1, 2);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 3);
        checkOutput("mrIdlePop", int'(pop), 0);
        checkOutput("mrIdlePopCnt", int'(pop_cnt), 0);
        checkOutput("mrIdleValid", int'(out_valid), 0);

`ifdef DRAIN_BURST_EN
        $display("[TB] burst");
        o0 = out_log.size();
        push_q(0, 8'hA1); push_q(0, 8'hA2); push_q(0, 8'hA3);
        push_q(1, 8'hB1);
        applyStimulus(1'b1, 1'b1, 8);
        exp_out[0] = ent(0, 'hA1); exp_out[1] = ent(0, 'hA2);
        exp_out[2] = ent(1, 'hB1); exp_out[3] = ent(0, 'hA3);
        for (int i = 0; i < 4; i++) begin
            checkOutput("burstOut", out_at(o0 + i), exp_out[i]);
        end
        checkOutput("burstPopCnt", int'(pop_cnt), 4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule
